pipe_ctrl: RTL and testbench

Central pipeline controller for the 5-stage core. It drives the `en` inputs of the pc, if_id, id_ex, ex_mem and mem_wb registers, and issues bubble/flush commands to them.
- Sources: per-stage stall requests, ID-stage load-use hazard detection, MEM-stage exception/redirect.
- Keeps a saturating stall-cycle performance counter.
- Combinational enables plus a small registered FSM for flush sequencing.

---
 rtl/pipe_pkg.sv | 67 ++++++
 rtl/hazard_ldu.sv | 29 ++
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline controller.
// Holds the FSM state and stall-source enums and the stage-control bundle decoder.
package pipe_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pipe_state_e;

  typedef enum logic [2:0] {
    STALL_NONE = 3'd0,
    STALL_IF   = 3'd1,
    STALL_ID   = 3'd2,
    STALL_EX   = 3'd3,
    STALL_MEM  = 3'd4
  } stall_src_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG  = 5'd0;

  typedef struct packed {
    logic en_pc;
    logic en_if_id;
    logic en_id_ex;
    logic en_ex_mem;
    logic en_mem_wb;
    logic bubble_id_ex;
    logic bubble_ex_mem;
    logic bubble_mem_wb;
  } pipe_ctl_t;

  // Registers up to the stalling stage hold, the next one takes a bubble, later ones advance.
  function automatic pipe_ctl_t ctl_for_src(input stall_src_e src);
    pipe_ctl_t c;
    c = '{en_pc: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1, en_ex_mem: 1'b1,
          en_mem_wb: 1'b1, bubble_id_ex: 1'b0, bubble_ex_mem: 1'b0,
          bubble_mem_wb: 1'b0};
    case (src)
      STALL_IF: begin
        c.en_pc = 1'b0;
      end
      STALL_ID: begin
        c.en_pc        = 1'b0;
        c.en_if_id     = 1'b0;
        c.bubble_id_ex = 1'b1;
      end
      STALL_EX: begin
        c.en_pc         = 1'b0;
        c.en_if_id      = 1'b0;
        c.en_id_ex      = 1'b0;
        c.bubble_ex_mem = 1'b1;
      end
      STALL_MEM: begin
        c.en_pc         = 1'b0;
        c.en_if_id      = 1'b0;
        c.en_id_ex      = 1'b0;
        c.en_ex_mem     = 1'b0;
        c.bubble_mem_wb = 1'b1;
      end
      default: begin
        c.en_pc = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_ldu.sv
// Load-use hazard comparator: flags an ID instruction that reads the register
// the load currently in EX is about to write. r0 is never a real dependency.
module hazard_ldu
  import pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            ex_is_load,
  input  logic [RA_W-1:0] ex_wd,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_rs_rd,
  input  logic            id_rt_rd,
  output logic            ldu
);

  logic wd_nz_s;
  logic rs_hit_s;
  logic rt_hit_s;

  // Compare both ID source operands against the EX load destination.
  always_comb begin
    wd_nz_s  = (ex_wd != RA_W'(NOP_REG));
    rs_hit_s = id_rs_rd & (id_rs == ex_wd);
    rt_hit_s = id_rt_rd & (id_rt == ex_wd);
    ldu      = ex_is_load & wd_nz_s & (rs_hit_s | rt_hit_s);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: combinational stage enables/bubbles from stall
// priority, a RUN/FLUSH FSM for exception redirect, and a saturating stall counter.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              ex_is_load,
  input  logic [RA_W-1:0]   ex_wd,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_rs_rd,
  input  logic              id_rt_rd,
  input  logic              mem_excp,
  input  logic [ADDR_W-1:0] mem_excp_pc,
  output logic              en_pc,
  output logic              en_if_id,
  output logic              en_id_ex,
  output logic              en_ex_mem,
  output logic              en_mem_wb,
  output logic              bubble_id_ex,
  output logic              bubble_ex_mem,
  output logic              bubble_mem_wb,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              ldu_s;
  logic              override_s;
  logic              stall_any_s;
  stall_src_e        src_s;
  pipe_ctl_t         ctl_s;

  pipe_state_e       state_q, state_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] new_pc_q, new_pc_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  hazard_ldu #(.RA_W(RA_W)) u_hazard_ldu (
    .ex_is_load (ex_is_load),
    .ex_wd      (ex_wd),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_rd   (id_rs_rd),
    .id_rt_rd   (id_rt_rd),
    .ldu        (ldu_s)
  );

  // Pick the highest-priority stalling stage; reset, a flush or a new exception releases everything.
  always_comb begin
    override_s = ~rst | (state_q == FLUSH) | mem_excp;
    if (override_s) begin
      src_s = STALL_NONE;
    end else if (stallreq_mem) begin
      src_s = STALL_MEM;
    end else if (stallreq_ex) begin
      src_s = STALL_EX;
    end else if (ldu_s) begin
      src_s = STALL_ID;
    end else if (stallreq_if) begin
      src_s = STALL_IF;
    end else begin
      src_s = STALL_NONE;
    end
    ctl_s       = ctl_for_src(src_s);
    stall_any_s = ~(ctl_s.en_pc & ctl_s.en_if_id & ctl_s.en_id_ex & ctl_s.en_ex_mem);
  end

  // Next-state logic for the flush sequencer, redirect target and stall counter.
  always_comb begin
    state_d     = state_q;
    flush_d     = 1'b0;
    new_pc_d    = new_pc_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_excp) begin
          state_d  = FLUSH;
          flush_d  = 1'b1;
          new_pc_d = mem_excp_pc;
        end else begin
          state_d  = RUN;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (stall_any_s) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      flush_q     <= 1'b0;
      new_pc_q    <= {ADDR_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      new_pc_q    <= new_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign en_pc         = ctl_s.en_pc;
  assign en_if_id      = ctl_s.en_if_id;
  assign en_id_ex      = ctl_s.en_id_ex;
  assign en_ex_mem     = ctl_s.en_ex_mem;
  assign en_mem_wb     = ctl_s.en_mem_wb;
  assign bubble_id_ex  = ctl_s.bubble_id_ex;
  assign bubble_ex_mem = ctl_s.bubble_ex_mem;
  assign bubble_mem_wb = ctl_s.bubble_mem_wb;
  assign flush         = flush_q;
  assign new_pc        = new_pc_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl (4-bit stall counter build).
module tb_pipe_ctrl;

  localparam int CNT_W  = 4;
  localparam int ADDR_W = 32;
  localparam int RA_W   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              stallreq_if, stallreq_ex, stallreq_mem;
  logic              ex_is_load;
  logic [RA_W-1:0]   ex_wd, id_rs, id_rt;
  logic              id_rs_rd, id_rt_rd;
  logic              mem_excp;
  logic [ADDR_W-1:0] mem_excp_pc;
  logic              en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic              bubble_id_ex, bubble_ex_mem, bubble_mem_wb;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .ex_is_load(ex_is_load), .ex_wd(ex_wd), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd),
    .mem_excp(mem_excp), .mem_excp_pc(mem_excp_pc),
    .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex), .en_ex_mem(en_ex_mem),
    .en_mem_wb(en_mem_wb), .bubble_id_ex(bubble_id_ex), .bubble_ex_mem(bubble_ex_mem),
    .bubble_mem_wb(bubble_mem_wb), .flush(flush), .new_pc(new_pc), .stall_cnt(stall_cnt)
  );

  // ctl bit order: en_pc en_if_id en_id_ex en_ex_mem en_mem_wb | b_id_ex b_ex_mem b_mem_wb
  localparam logic [7:0] C_RUN = 8'b11111_000;
  localparam logic [7:0] C_IF  = 8'b01111_000;
  localparam logic [7:0] C_ID  = 8'b00111_100;
  localparam logic [7:0] C_EX  = 8'b00011_010;
  localparam logic [7:0] C_MEM = 8'b00001_001;

  typedef struct {
    string      name;
    logic       rst, sif, sex, smem, ld;
    logic [4:0] wd, rs, rt;
    logic       rs_rd, rt_rd;
    logic [7:0] ctl;
  } vec_t;

  vec_t vecs[14];
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_cnt = 4'h0;

  function automatic vec_t mk(input string n, input logic r, input logic sif, input logic sex,
                              input logic smem, input logic ld, input logic [4:0] wd,
                              input logic [4:0] rs, input logic [4:0] rt, input logic rsr,
                              input logic rtr, input logic [7:0] ctl);
    vec_t v;
    v.name = n; v.rst = r; v.sif = sif; v.sex = sex; v.smem = smem; v.ld = ld;
    v.wd = wd; v.rs = rs; v.rt = rt; v.rs_rd = rsr; v.rt_rd = rtr; v.ctl = ctl;
    return v;
  endfunction

  function automatic logic [7:0] ctl_now();
    return {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
            bubble_id_ex, bubble_ex_mem, bubble_mem_wb};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    stallreq_if = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    ex_is_load = 1'b0; ex_wd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    id_rs_rd = 1'b0; id_rt_rd = 1'b0; mem_excp = 1'b0; mem_excp_pc = 32'h0;
  endtask

  // Advance one clock, update the counter model, and compare stall_cnt.
  task automatic tick(input logic stalled, input string nm);
    @(posedge clk);
    if (!rst) exp_cnt = 4'h0;
    else if (stalled && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'h1;
    #1;
    chk(nm, 32'(stall_cnt), 32'(exp_cnt));
  endtask

  initial begin
    vecs[0]  = mk("v_none",      1'b1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_RUN);
    vecs[1]  = mk("v_ldu_rs",    1'b1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, C_ID);
    vecs[2]  = mk("v_ldu_wd0",   1'b1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, C_RUN);
    vecs[3]  = mk("v_ldu_rt",    1'b1, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 1, C_ID);
    vecs[4]  = mk("v_rs_noread", 1'b1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd3, 0, 1, C_RUN);
    vecs[5]  = mk("v_notload",   1'b1, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, 1, 1, C_RUN);
    vecs[6]  = mk("v_if",        1'b1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_IF);
    vecs[7]  = mk("v_ex",        1'b1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_EX);
    vecs[8]  = mk("v_ex_ldu",    1'b1, 0, 1, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0, C_EX);
    vecs[9]  = mk("v_mem",       1'b1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_MEM);
    vecs[10] = mk("v_mem_all",   1'b1, 1, 1, 1, 1, 5'd4, 5'd4, 5'd4, 1, 1, C_MEM);
    vecs[11] = mk("v_if_ldu",    1'b1, 1, 0, 0, 1, 5'd31, 5'd2, 5'd31, 1, 1, C_ID);
    vecs[12] = mk("v_rst_reqs",  1'b0, 1, 1, 1, 1, 5'd4, 5'd4, 5'd4, 1, 1, C_RUN);
    vecs[13] = mk("v_after_rst", 1'b1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_RUN);

    // Reset state
    idle();
    rst = 1'b0;
    tick(1'b0, "rst_cnt0");
    tick(1'b0, "rst_cnt1");
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_ctl", 32'(ctl_now()), 32'(C_RUN));
    rst = 1'b1;

    // Idle pipeline for 10 cycles
    for (int i = 0; i < 10; i++) begin
      #1 chk("idle_ctl", 32'(ctl_now()), 32'(C_RUN));
      tick(1'b0, "idle_cnt");
    end

    // Table of single-cycle vectors
    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rst; stallreq_if = vecs[i].sif; stallreq_ex = vecs[i].sex;
      stallreq_mem = vecs[i].smem; ex_is_load = vecs[i].ld; ex_wd = vecs[i].wd;
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_rs_rd = vecs[i].rs_rd;
      id_rt_rd = vecs[i].rt_rd; mem_excp = 1'b0;
      #1 chk(vecs[i].name, 32'(ctl_now()), 32'(vecs[i].ctl));
      tick(~&vecs[i].ctl[7:4], vecs[i].name);
    end
    idle();
    rst = 1'b1;

    // EX stall for 4 cycles with a concurrent load-use
    stallreq_ex = 1'b1; ex_is_load = 1'b1; ex_wd = 5'd6; id_rs = 5'd6; id_rs_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("ex_ldu_ctl", 32'(ctl_now()), 32'(C_EX));
      tick(1'b1, "ex_ldu_cnt");
    end
    chk("ex_ldu_cnt4", 32'(stall_cnt), 32'h4);
    idle();

    // Exception during a MEM stall
    stallreq_mem = 1'b1; mem_excp = 1'b1; mem_excp_pc = 32'hBFC0_0380;
    #1 chk("excp_ctl", 32'(ctl_now()), 32'(C_RUN));
    tick(1'b0, "excp_cnt");
    chk("excp_flush1", 32'(flush), 32'h1);
    chk("excp_new_pc", new_pc, 32'hBFC0_0380);
    mem_excp = 1'b0;
    #1 chk("flush_ctl", 32'(ctl_now()), 32'(C_RUN));
    tick(1'b0, "flush_cnt");
    chk("excp_flush0", 32'(flush), 32'h0);
    idle();

    // Back-to-back exceptions: the second one lands in FLUSH and is ignored
    mem_excp = 1'b1; mem_excp_pc = 32'hBFC0_0380;
    tick(1'b0, "b2b_cnt0");
    chk("b2b_flush1", 32'(flush), 32'h1);
    mem_excp_pc = 32'h8000_0000;
    tick(1'b0, "b2b_cnt1");
    mem_excp = 1'b0;
    chk("b2b_flush0", 32'(flush), 32'h0);
    chk("b2b_new_pc", new_pc, 32'hBFC0_0380);
    tick(1'b0, "b2b_cnt2");
    chk("b2b_flush_quiet", 32'(flush), 32'h0);
    idle();

    // Long MEM stall drives the 4-bit counter into saturation
    stallreq_mem = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1 chk("sat_ctl", 32'(ctl_now()), 32'(C_MEM));
      tick(1'b1, "sat_cnt");
    end
    chk("sat_cnt_F", 32'(stall_cnt), 32'hF);

    // Reset asserted while in FLUSH aborts the flush
    mem_excp = 1'b1; mem_excp_pc = 32'h1234_5678;
    tick(1'b0, "pre_rst_cnt");
    chk("pre_rst_flush", 32'(flush), 32'h1);
    mem_excp = 1'b0; rst = 1'b0;
    tick(1'b0, "midflush_rst_cnt");
    chk("midflush_rst_flush", 32'(flush), 32'h0);
    chk("midflush_rst_cnt0", 32'(stall_cnt), 32'h0);
    chk("midflush_rst_pc", new_pc, 32'h0);
    rst = 1'b1; idle();
    tick(1'b0, "post_rst_cnt");
    chk("post_rst_flush", 32'(flush), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
